// File: rtl/clock_switch_pkg.sv
// clock_switch_pkg: shared state type and counter sizing for the clock-switch sequencer
package clock_switch_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_LOCK, SETTLE, HOLDOFF, DONE} clksw_state_t;
  function automatic int clog2w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/clock_switch_ctrl_lock_sync.sv
// lock_sync: SYNC_STAGES-deep flop chain bringing an asynchronous level into the clk_i domain
module lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] r_sync;
  always_ff @(posedge clk_i)
    if (rst_i) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
  assign q_o = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: drives the clock-mux select only after the alternate clock's lock is qualified.
// Define CLKSW_TIMEOUT_EN to abort lock qualification after TIMEOUT_CYCLES with an err_o pulse.
module clock_switch_ctrl
  import clock_switch_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  input  logic lock_i,
  output logic locked_o,
  output logic sel_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);
  localparam int CNT_TOP = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
  localparam int CW = clog2w(CNT_TOP);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CNT_TOP);
  localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);

  if (SYNC_STAGES < 2 || SETTLE_CYCLES < 1 || HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("clock_switch_ctrl: parameter out of range");
  end

  clksw_state_t r_state, w_next;
  logic          r_sel, w_sel_next, w_locked, w_timeout;
  logic [CW-1:0] r_cnt;

  lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (lock_i),
    .q_o   (w_locked)
  );

`ifdef CLKSW_TIMEOUT_EN
  localparam int TW = clog2w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] r_tcnt;
  logic          w_qual;
  assign w_qual = (r_state == WAIT_LOCK) || (r_state == SETTLE);
  // Spans WAIT_LOCK and SETTLE, so lock dropouts do not restart the budget
  always_ff @(posedge clk_i)
    if (rst_i || r_state == IDLE) r_tcnt <= '0;
    else if (w_qual && r_tcnt != TO_MAX) r_tcnt <= r_tcnt + 1'b1;
  assign w_timeout = w_qual && (r_tcnt == TO_MAX);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_sel_next = r_sel;
    case (r_state)
      IDLE:
        if (req_valid_i) begin
          w_next     = (req_sel_i == r_sel) ? DONE : req_sel_i ? WAIT_LOCK : HOLDOFF;
          w_sel_next = r_sel & req_sel_i;
        end
      WAIT_LOCK: w_next = w_timeout ? IDLE : w_locked ? SETTLE : WAIT_LOCK;
      SETTLE: begin
        w_next     = w_timeout ? IDLE : !w_locked ? WAIT_LOCK : (r_cnt == SET_LAST) ? HOLDOFF : SETTLE;
        w_sel_next = r_sel | (!w_timeout && w_locked && r_cnt == SET_LAST);
      end
      HOLDOFF: w_next = (r_cnt == HOLD_LAST) ? DONE : HOLDOFF;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Phase counter restarts on every state change, so each state counts its own residency
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel_next;
      r_cnt   <= (w_next != r_state) ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end

  assign locked_o    = w_locked;
  assign sel_o       = r_sel;
  assign req_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign err_o       = w_timeout;
endmodule

// File: doc/clock_switch_ctrl.md
# clock_switch_ctrl

Sequencer that drives the select input of the design's two-input clock mux. Runs on the always-on reference clock, accepts clock-switch requests over a valid/ready handshake, qualifies the alternate clock's PLL lock through a synchronizer, and holds lock stable for a settle window before changing `sel_o`. After a hold-off window it reports completion, so downstream logic never sees a select change on an unqualified clock.

## Interface
- `SYNC_STAGES`, 2: flops in the lock synchronizer (≥2).
- `SETTLE_CYCLES`, 16: consecutive cycles of synced lock required before `sel_o` changes to 1 (≥1).
- `HOLDOFF_CYCLES`, 8: cycles between the `sel_o` change and `done_o` (≥1).
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent qualifying lock before abort (≥1). Active only with `CLKSW_TIMEOUT_EN`.

- `clk_i` input 1: always-on reference clock; identical to mux input 0.
- `rst_i` input 1: synchronous, active-high reset.
- `req_valid_i` input 1: switch request valid.
- `req_sel_i` input 1: requested select value.
- `req_ready_o` output 1: request accepted when high together with `req_valid_i`.
- `lock_i` input 1: asynchronous PLL lock for clock 1.
- `locked_o` output 1: synchronized lock.
- `sel_o` output 1: select to the clock mux.
- `busy_o` output 1: high in every state except IDLE.
- `done_o` output 1: one-cycle completion pulse.
- `err_o` output 1: one-cycle abort pulse.

## Operation
- Reset values: `sel_o`=0, `req_ready_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0, `locked_o`=0, synchronizer flops=0, state=IDLE, all counters=0.
- States: IDLE, WAIT_LOCK, SETTLE, HOLDOFF, DONE.
- IDLE: `req_ready_o`=1. On accept:
  - `req_sel_i`==`sel_o`: go to DONE, with no select change.
  - `req_sel_i`=0: set `sel_o`=0 and go to HOLDOFF. No lock check is made for target 0, because clock 0 is the reference.
  - `req_sel_i`=1: go to WAIT_LOCK and clear the timeout counter.
- WAIT_LOCK: when `locked_o`=1, go to SETTLE with the settle counter at 0.
- SETTLE:
  - Counts `locked_o`-high cycles.
  - If `locked_o` drops, return to WAIT_LOCK. The settle counter clears; the timeout counter keeps running.
  - When the count reaches `SETTLE_CYCLES`, set `sel_o`=1 and go to HOLDOFF.
- HOLDOFF: after `HOLDOFF_CYCLES` cycles, go to DONE. Lock loss is ignored here.
- DONE: `done_o`=1 for exactly one cycle, then go to IDLE.
- Counters are `$clog2(max+1)` wide and saturate; they never wrap.
- Reset mid-operation: all state returns to reset values in the next cycle, including `sel_o`=0. Clock 0 is always safe.

## Timing
- Request accepted at edge E (`req_valid_i` & `req_ready_o` sampled).
- Same-target request: `done_o` is high in cycle E+1 and `req_ready_o` returns at E+2.
- Target 0 from 1: `sel_o`=0 from E+1; `done_o` at E+1+`HOLDOFF_CYCLES`.
- Target 1 with lock already synced:
  - WAIT_LOCK at E+1.
  - `sel_o`=1 from E+2+`SETTLE_CYCLES`.
  - `done_o` at E+2+`SETTLE_CYCLES`+`HOLDOFF_CYCLES`.
- Lock latency: `lock_i` edge reaches `locked_o` after `SYNC_STAGES` cycles.
- `req_valid_i` while busy is ignored; `req_ready_o`=0. The requester holds the request until accepted.
- `done_o` and `err_o` are never high in the same cycle.

## Configuration
- `CLKSW_TIMEOUT_EN` defined:
  - The timeout counter runs in WAIT_LOCK and SETTLE.
  - On reaching `TIMEOUT_CYCLES`: `err_o`=1 for one cycle, return to IDLE, `sel_o` unchanged (stays 0), no `done_o`.
- `CLKSW_TIMEOUT_EN` undefined:
  - No timeout counter is synthesized.
  - WAIT_LOCK waits indefinitely.
  - `err_o` is tied to 0.

## Structure
- Package `clock_switch_pkg`: state enum typedef `clksw_state_t`, plus a width helper constant function for counter sizing.
- Sub-module `lock_sync`: parameterized `SYNC_STAGES` flop chain with synchronous active-high reset to 0. It is instantiated once for `lock_i`.

## Test plan
- Reset, then request 1 with `lock_i`=1, `SETTLE_CYCLES`=16, `HOLDOFF_CYCLES`=8 -> `sel_o` rises 18 cycles after accept; `done_o` is a single pulse 8 cycles later.
- With `sel_o`=1, request 1 -> `done_o` the next cycle, `sel_o` stays 1, no SETTLE entered.
- `lock_i` drops for 3 cycles mid-SETTLE -> return to WAIT_LOCK; `sel_o` rises only after 16 fresh consecutive locked cycles.
- `CLKSW_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, `lock_i`=0 -> `err_o` pulse 100 cycles after WAIT_LOCK entry, `sel_o`=0, `req_ready_o`=1 the next cycle.
- Assert `rst_i` during HOLDOFF after `sel_o`=1 -> the next cycle `sel_o`=0, state IDLE, and no `done_o`.
- Request while busy -> `req_ready_o`=0 and the request is not consumed; it is accepted on the cycle after DONE.
